// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types for the CPU memory bridge: FSM and owner encodings plus bus widths.
package cpu_mem_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StResp = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnInst = 2'd1,
        OwnData = 2'd2
    } owner_e;

    // Reads always present an all-zero byte-enable on the bus.
    function automatic logic [STRB_W-1:0] bus_strb(input logic wr, input logic [STRB_W-1:0] strb);
        return wr ? strb : '0;
    endfunction

endpackage

// File: rtl/rr_starve_arb.sv
// Data-first arbiter between fetch and load/store, with a counter that forces a fetch
// through once STARVE_MAX data grants have gone by while the fetch was waiting.
module rr_starve_arb
    import cpu_mem_bridge_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst,
    output logic grant_data
);

    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] starve_cnt_q;
    logic            starved;

    assign starved = inst_req && (starve_cnt_q == CntMax);

    always_comb begin
        grant_data = en && data_req && !starved;
        grant_inst = en && inst_req && !grant_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (grant_inst) begin
            starve_cnt_q <= '0;
        end else if (grant_data && inst_req && (starve_cnt_q != CntMax)) begin
            starve_cnt_q <= starve_cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Merges the core's fetch and load/store channels onto one req/gnt/rvalid memory bus,
// one transaction in flight at a time.
module cpu_mem_bridge
    import cpu_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q;
    owner_e              owner_q;
    logic                mem_req_q;
    logic                mem_wr_q;
    logic [STRB_W-1:0]   mem_wstrb_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                inst_data_ok_q;
    logic                data_data_ok_q;
    logic [DATA_W-1:0]   inst_rdata_q;
    logic [DATA_W-1:0]   data_rdata_q;

    logic                arb_en;
    logic                grant_inst;
    logic                grant_data;
    logic                resp_now;

    // Gated by reset so no addr_ok can leak out while the FSM is being cleared.
    assign arb_en = (state_q == StIdle) && !reset;

    rr_starve_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .en         (arb_en),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // rvalid only counts once the request has been granted; earlier pulses are ignored.
    assign resp_now = ((state_q == StReq) && mem_gnt && mem_rvalid) ||
                      ((state_q == StWait) && mem_rvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            owner_q        <= OwnNone;
            mem_req_q      <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_wstrb_q    <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
        end else begin
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (grant_data) begin
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= data_wr;
                        mem_wstrb_q <= bus_strb(data_wr, data_wstrb);
                        mem_addr_q  <= data_addr;
                        mem_wdata_q <= data_wdata;
                        owner_q     <= OwnData;
                        state_q     <= StReq;
                    end else if (grant_inst) begin
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= 1'b0;
                        mem_wstrb_q <= '0;
                        mem_addr_q  <= inst_addr;
                        mem_wdata_q <= '0;
                        owner_q     <= OwnInst;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_rvalid ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    owner_q <= OwnNone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (resp_now) begin
                inst_data_ok_q <= (owner_q == OwnInst);
                data_data_ok_q <= (owner_q == OwnData);
                if (owner_q == OwnInst) begin
                    inst_rdata_q <= mem_rdata;
                end
                // Store acks leave the last load word intact.
                if ((owner_q == OwnData) && !mem_wr_q) begin
                    data_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign mem_req      = mem_req_q;
    assign mem_wr       = mem_wr_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits directly downstream of the CPU core's instruction and data memory ports.
- Converts two request/response channels (fetch, load/store) into one variable-latency memory bus with a req/gnt/rvalid handshake.
- At most one transaction is outstanding. Data has priority, with a starvation guard for instruction fetch.
- Lets the core run against slow or shared memory instead of fixed 1-cycle SRAM.

Parameters:
- ADDR_W, 32, address width of all channels.
- STARVE_MAX, 4, consecutive data grants allowed while inst_req is pending before inst is forced first.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address (word aligned)
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
inst_rdata  out  32  fetched word, held until next inst_data_ok
data_req  in  1  load/store request, held until data_addr_ok
data_wr  in  1  1 = store, 0 = load
data_wstrb  in  4  byte enables for stores
data_addr  in  ADDR_W  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  one-cycle pulse: load data valid or store complete
data_rdata  out  32  load word, held until next data_data_ok
mem_req  out  1  bus request, registered
mem_wr  out  1  bus write
mem_wstrb  out  4  bus byte enables (4'h0 for reads)
mem_addr  out  ADDR_W  bus address
mem_wdata  out  32  bus write data
mem_gnt  in  1  bus accepted request (valid only while mem_req=1)
mem_rvalid  in  1  read data or write ack, one cycle
mem_rdata  in  32  bus read data

Behaviour:
Reset values:
- All outputs 0; rdata registers 0.
- FSM in IDLE; starvation counter 0; owner = none.

FSM states are IDLE, REQ, WAIT, RESP.

IDLE:
- Selects one requester:
  - data wins if data_req=1, unless inst_req=1 and starve_cnt==STARVE_MAX, in which case inst wins.
  - inst wins if only inst_req=1.
- The winner's addr_ok is driven combinationally high in this same cycle (the only cycle it is high).
- In that cycle: latch wr/wstrb/addr/wdata (fetch: wr=0, wstrb=0), record owner, go to REQ.
- Starvation counter:
  - increments on a data grant while inst_req=1, saturating at STARVE_MAX;
  - clears on any inst grant.
- No request: stay in IDLE.

REQ:
- mem_req=1, with mem_* driven from the latched registers and held stable.
- On mem_gnt=1: deassert mem_req next cycle and go to WAIT.
- If mem_rvalid and mem_gnt arrive in the same cycle: capture rdata and go directly to RESP.

WAIT:
- On mem_rvalid=1: capture mem_rdata (loads and fetches only; stores do not update rdata) and go to RESP.

RESP:
- The owner's data_ok is 1 for exactly one cycle; the rdata output holds the captured word.
- Next state is IDLE. New requests are not accepted in RESP.
- Minimum latency is addr_ok → data_ok = 3 cycles (gnt in the first REQ cycle, rvalid the next cycle).

Rules and boundary conditions:
- addr_ok is never asserted outside IDLE. Both addr_ok signals are never high together.
- data_ok is never asserted for a channel that does not own the transaction.
- mem_rvalid seen in IDLE or REQ (before gnt) is a protocol error: ignored, no state change.
- Reset mid-transaction:
  - returns to IDLE and drops the transaction; mem_req=0 the next cycle;
  - a late mem_rvalid after reset is ignored per the rule above.
- Requester deasserts req while in REQ/WAIT: no effect, since the request is already latched.
- Address and data are not checked or modified. Alignment is the core's responsibility.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/WAIT/RESP, 2 bits), owner encoding (OWN_NONE/OWN_INST/OWN_DATA), bus width constants.
- Sub-module rr_starve_arb: the priority and starvation-counter logic, producing grant_inst/grant_data. Everything else stays in one module.

Test Plan:
- Load, fixed latency: data_req=1, wr=0, addr=0x1c000100; memory gives gnt in the first REQ cycle, rvalid+rdata=0xdeadbeef one cycle later → data_addr_ok at t0, mem_req t1, data_data_ok at t3 with data_rdata=0xdeadbeef; inst_data_ok stays 0.
- Store: wr=1, wstrb=4'b0011, wdata=0x12345678 → mem_wr=1, mem_wstrb=4'b0011, mem_wdata stable until gnt; data_data_ok pulses after rvalid; data_rdata unchanged.
- Simultaneous requests, STARVE_MAX=2: inst_req and data_req held high → grant order data, data, inst, data, data, inst; the counter resets after each inst grant.
- Variable latency: gnt delayed 5 cycles and rvalid delayed 7 cycles → mem_req held with all mem_* stable for 5 cycles; no addr_ok during the transaction; exactly one data_ok.
- Same-cycle gnt+rvalid: rvalid asserted with gnt → response at the next cycle (RESP), with correct rdata.
- Reset in WAIT: assert reset, then send a stray rvalid → no data_ok; next request completes normally.
